// File: rtl/issue_if.sv
// Queue-head / CDB / issue-slot bundle between the instruction queue, the issue stage and the reservation stations.
// Latency: none, signal grouping only.
// Backpressure: the issue stage answers the queue through select_instruction (advance count).
interface issue_if #(
  parameter int TAG_W = 3
);
  logic [1:0]       iq_count;
  logic [7:0]       inst1_type;
  logic [7:0]       inst1_destination_reg;
  logic [7:0]       inst1_source_reg1;
  logic [7:0]       inst1_source_reg2;
  logic [7:0]       inst2_type;
  logic [7:0]       inst2_destination_reg;
  logic [7:0]       inst2_source_reg1;
  logic [7:0]       inst2_source_reg2;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [1:0]       select_instruction;
  logic             iss1_valid;
  logic             iss2_valid;
  logic [TAG_W-1:0] iss1_tag;
  logic [TAG_W-1:0] iss2_tag;
  logic [7:0]       iss1_op;
  logic [7:0]       iss2_op;
  logic [2:0]       iss1_src1;
  logic [2:0]       iss1_src2;
  logic [2:0]       iss2_src1;
  logic [2:0]       iss2_src2;
  logic [TAG_W-1:0] iss1_qj;
  logic [TAG_W-1:0] iss1_qk;
  logic [TAG_W-1:0] iss2_qj;
  logic [TAG_W-1:0] iss2_qk;

  // Queue/CDB side: presents instructions and broadcasts, observes issue results.
  modport master (
    output iq_count, inst1_type, inst1_destination_reg, inst1_source_reg1, inst1_source_reg2,
    output inst2_type, inst2_destination_reg, inst2_source_reg1, inst2_source_reg2,
    output cdb_valid, cdb_tag,
    input  select_instruction, iss1_valid, iss2_valid, iss1_tag, iss2_tag, iss1_op, iss2_op,
    input  iss1_src1, iss1_src2, iss2_src1, iss2_src2, iss1_qj, iss1_qk, iss2_qj, iss2_qk
  );

  // Issue stage side.
  modport slave (
    input  iq_count, inst1_type, inst1_destination_reg, inst1_source_reg1, inst1_source_reg2,
    input  inst2_type, inst2_destination_reg, inst2_source_reg1, inst2_source_reg2,
    input  cdb_valid, cdb_tag,
    output select_instruction, iss1_valid, iss2_valid, iss1_tag, iss2_tag, iss1_op, iss2_op,
    output iss1_src1, iss1_src2, iss2_src1, iss2_src2, iss1_qj, iss1_qk, iss2_qj, iss2_qk
  );
endinterface

// File: rtl/issue_unit.sv
// Dual in-order issue: allocates add/mul RS entries, renames sources via a register status table.
// Latency: select_instruction combinational in cycle N, iss* registered and valid in cycle N+1.
// Backpressure: a slot whose RS class is full stalls it and everything younger (00 or 01 advance).
module issue_unit #(
  parameter int NUM_REGS = 8,
  parameter int ADD_RS   = 3,
  parameter int MUL_RS   = 2,
  parameter int TAG_W    = 3
) (
  input logic   clk,
  input logic   rst_n,
  issue_if.slave bus
);
  localparam int REG_W = $clog2(NUM_REGS);

  typedef enum logic [1:0] {CLS_NOP, CLS_ADD, CLS_MUL} cls_e;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [7:0]       op;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
  } slot_t;

  logic [ADD_RS-1:0] add_busy_q, add_busy_d;
  logic [MUL_RS-1:0] mul_busy_q, mul_busy_d;
  logic [TAG_W-1:0]  rstat_q [NUM_REGS];
  logic [TAG_W-1:0]  rstat_d [NUM_REGS];
  slot_t             iss1_q, iss1_d, iss2_q, iss2_d;

  cls_e              cls1, cls2;
  logic [1:0]        cnt;
  logic [ADD_RS-1:0] add_free, add_left, add_pick1, add_pick2;
  logic [MUL_RS-1:0] mul_free, mul_left, mul_pick1, mul_pick2;
  logic              s1_go, s2_go, s1_wr, s2_wr;
  logic [TAG_W-1:0]  tag1, tag2, q1j, q1k, q2j, q2k;

  function automatic cls_e cls_of(input logic [7:0] t);
    cls_e c;
    case (t)
      8'd1, 8'd2: c = CLS_ADD;
      8'd3, 8'd4: c = CLS_MUL;
      default:    c = CLS_NOP;
    endcase
    return c;
  endfunction

  function automatic logic [TAG_W-1:0] add_tag(input logic [ADD_RS-1:0] oh);
    logic [TAG_W-1:0] t;
    t = '0;
    for (int i = 0; i < ADD_RS; i++) if (oh[i]) t = TAG_W'(i + 1);
    return t;
  endfunction

  function automatic logic [TAG_W-1:0] mul_tag(input logic [MUL_RS-1:0] oh);
    logic [TAG_W-1:0] t;
    t = '0;
    for (int i = 0; i < MUL_RS; i++) if (oh[i]) t = TAG_W'(ADD_RS + i + 1);
    return t;
  endfunction

  // Table lookup with same-cycle CDB bypass so a result broadcast now is not waited on.
  function automatic logic [TAG_W-1:0] rename(input logic [7:0] src);
    logic [TAG_W-1:0] q;
    q = rstat_q[src[REG_W-1:0]];
    if (bus.cdb_valid && q == bus.cdb_tag) q = '0;
    return q;
  endfunction

  // Issue decision: slot1 allocation first, slot2 sees what slot1 left behind.
  always_comb begin
    cnt       = (bus.iq_count == 2'd3) ? 2'd2 : bus.iq_count;
    cls1      = cls_of(bus.inst1_type);
    cls2      = cls_of(bus.inst2_type);
    add_free  = ~add_busy_q;
    mul_free  = ~mul_busy_q;
    add_pick1 = add_free & (~add_free + ADD_RS'(1));
    mul_pick1 = mul_free & (~mul_free + MUL_RS'(1));
    s1_go     = (cnt != 2'd0) && ((cls1 == CLS_NOP) ||
                                  (cls1 == CLS_ADD && |add_free) ||
                                  (cls1 == CLS_MUL && |mul_free));
    s1_wr     = s1_go && (cls1 != CLS_NOP);
    add_left  = add_free & ~((s1_wr && cls1 == CLS_ADD) ? add_pick1 : '0);
    mul_left  = mul_free & ~((s1_wr && cls1 == CLS_MUL) ? mul_pick1 : '0);
    add_pick2 = add_left & (~add_left + ADD_RS'(1));
    mul_pick2 = mul_left & (~mul_left + MUL_RS'(1));
    s2_go     = s1_go && (cnt == 2'd2) && ((cls2 == CLS_NOP) ||
                                           (cls2 == CLS_ADD && |add_left) ||
                                           (cls2 == CLS_MUL && |mul_left));
    s2_wr     = s2_go && (cls2 != CLS_NOP);
    tag1      = (cls1 == CLS_ADD) ? add_tag(add_pick1) : mul_tag(mul_pick1);
    tag2      = (cls2 == CLS_ADD) ? add_tag(add_pick2) : mul_tag(mul_pick2);
    q1j       = rename(bus.inst1_source_reg1);
    q1k       = rename(bus.inst1_source_reg2);
    // slot1's destination is not in the table yet, so slot2 must take it directly
    q2j       = (s1_wr && bus.inst2_source_reg1[REG_W-1:0] == bus.inst1_destination_reg[REG_W-1:0])
                ? tag1 : rename(bus.inst2_source_reg1);
    q2k       = (s1_wr && bus.inst2_source_reg2[REG_W-1:0] == bus.inst1_destination_reg[REG_W-1:0])
                ? tag1 : rename(bus.inst2_source_reg2);
  end

  assign bus.select_instruction = {s2_go, s1_go & ~s2_go};

  // Next state: CDB releases first, then slot1 and slot2 claims (later writes win).
  always_comb begin
    add_busy_d = add_busy_q;
    mul_busy_d = mul_busy_q;
    rstat_d    = rstat_q;
    if (bus.cdb_valid) begin
      for (int i = 0; i < ADD_RS; i++) if (bus.cdb_tag == TAG_W'(i + 1)) add_busy_d[i] = 1'b0;
      for (int i = 0; i < MUL_RS; i++) if (bus.cdb_tag == TAG_W'(ADD_RS + i + 1)) mul_busy_d[i] = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) if (rstat_q[r] == bus.cdb_tag) rstat_d[r] = '0;
    end
    if (s1_wr) begin
      if (cls1 == CLS_ADD) add_busy_d = add_busy_d | add_pick1;
      else                 mul_busy_d = mul_busy_d | mul_pick1;
      rstat_d[bus.inst1_destination_reg[REG_W-1:0]] = tag1;
    end
    if (s2_wr) begin
      if (cls2 == CLS_ADD) add_busy_d = add_busy_d | add_pick2;
      else                 mul_busy_d = mul_busy_d | mul_pick2;
      rstat_d[bus.inst2_destination_reg[REG_W-1:0]] = tag2;
    end
    iss1_d     = iss1_q;
    iss1_d.vld = 1'b0;
    if (s1_wr) iss1_d = '{vld: 1'b1, tag: tag1, op: bus.inst1_type,
                          src1: bus.inst1_source_reg1[REG_W-1:0],
                          src2: bus.inst1_source_reg2[REG_W-1:0], qj: q1j, qk: q1k};
    iss2_d     = iss2_q;
    iss2_d.vld = 1'b0;
    if (s2_wr) iss2_d = '{vld: 1'b1, tag: tag2, op: bus.inst2_type,
                          src1: bus.inst2_source_reg1[REG_W-1:0],
                          src2: bus.inst2_source_reg2[REG_W-1:0], qj: q2j, qk: q2k};
  end

  // State and issue-slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_busy_q <= '0;
      mul_busy_q <= '0;
      for (int r = 0; r < NUM_REGS; r++) rstat_q[r] <= '0;
      iss1_q     <= '0;
      iss2_q     <= '0;
    end else begin
      add_busy_q <= add_busy_d;
      mul_busy_q <= mul_busy_d;
      rstat_q    <= rstat_d;
      iss1_q     <= iss1_d;
      iss2_q     <= iss2_d;
    end
  end

  assign bus.iss1_valid = iss1_q.vld;
  assign bus.iss1_tag   = iss1_q.tag;
  assign bus.iss1_op    = iss1_q.op;
  assign bus.iss1_src1  = iss1_q.src1;
  assign bus.iss1_src2  = iss1_q.src2;
  assign bus.iss1_qj    = iss1_q.qj;
  assign bus.iss1_qk    = iss1_q.qk;
  assign bus.iss2_valid = iss2_q.vld;
  assign bus.iss2_tag   = iss2_q.tag;
  assign bus.iss2_op    = iss2_q.op;
  assign bus.iss2_src1  = iss2_q.src1;
  assign bus.iss2_src2  = iss2_q.src2;
  assign bus.iss2_qj    = iss2_q.qj;
  assign bus.iss2_qk    = iss2_q.qk;
endmodule

// File: doc/issue_unit.md
# issue_unit

Dual-issue stage directly downstream of `Instruction_Queue`: each cycle it consumes up to two queue-head instructions, allocates Tomasulo reservation-station (RS) entries, renames sources through a register status table, and returns the advance count on `select_instruction`. CDB broadcasts free RS entries and clear register tags. Issue outputs feed the add/mul reservation stations.

## Interface
- `NUM_REGS`, 8: architectural registers; register fields use low 3 bits, upper bits ignored.
- `ADD_RS`, 3: ADD/SUB RS entries, tags 1..3.
- `MUL_RS`, 2: MUL/DIV RS entries, tags 4..5.
- `TAG_W`, 3: tag width; tag 0 = value ready.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `iq_count` in 2: valid instructions at queue head (0,1,2; 3 treated as 2).
- `inst1_type`, `inst1_destination_reg`, `inst1_source_reg1`, `inst1_source_reg2` in 8 each: oldest instruction.
- `inst2_type`, `inst2_destination_reg`, `inst2_source_reg1`, `inst2_source_reg2` in 8 each: next instruction.
- `cdb_valid` in 1, `cdb_tag` in TAG_W: result broadcast.
- `select_instruction` out 2: queue advance: 00 none, 01 one, 10 two. Combinational.
- `iss1_valid`, `iss2_valid` out 1: issue slot valid (registered).
- `iss1_tag`, `iss2_tag` out TAG_W: allocated RS tag.
- `iss1_op`, `iss2_op` out 8: instruction type.
- `iss1_src1`, `iss1_src2`, `iss2_src1`, `iss2_src2` out 3: source register indices.
- `iss1_qj`, `iss1_qk`, `iss2_qj`, `iss2_qk` out TAG_W: producer tags (0 = read register file).

## Operation
- Types: 0 NOP, 1 ADD, 2 SUB → add class; 3 MUL, 4 DIV → mul class; any other value treated as NOP.
- State: `add_busy[ADD_RS]`, `mul_busy[MUL_RS]`, per-register `rstat_tag[NUM_REGS]` (0 = no pending producer).
- Slot1 eligible if `iq_count>=1`; issues if NOP, or its class has a free entry.
- Slot2 eligible if `iq_count==2` and slot1 issued; issues if NOP or a free entry remains after slot1's allocation. Strictly in order: slot2 never issues alone.
- Allocation: lowest-index free entry of the class; slot1 before slot2.
- NOP consumes a queue slot, sets no busy bit, changes no status; its `issN_valid` stays 0.
- Source rename: q = `rstat_tag[src]`, forced to 0 if `cdb_valid` and q==`cdb_tag` (same-cycle bypass). For slot2, a source equal to slot1's issued non-NOP destination takes slot1's tag (overrides table).
- Status update at edge: CDB first clears every `rstat_tag` equal to `cdb_tag`; then slot1 dest write, then slot2 dest write (slot2 wins on same dest). New writes override the CDB clear.
- CDB frees busy entry `cdb_tag`; freed entry is allocatable next cycle, not the same cycle. `cdb_tag` 0 or >5 ignored.
- `select_instruction` = number of slots issued (NOP included).

## Timing
- Decision combinational in cycle N from queue outputs and current state; `select_instruction` valid in cycle N, sampled by queue at edge N.
- `iss*` outputs registered at edge N, valid for exactly cycle N+1; `issN_valid` low in cycles with no issue (other fields hold last value).
- Reset (async, any time): all busy bits 0, all `rstat_tag` 0, all `iss*` outputs 0; `select_instruction` reflects reset state combinationally (no RS busy). In-flight issue discarded.
- Full: all entries of needed class busy → slot stalls, `select_instruction`=00 (slot1) or 01 (slot2 stall).

## Test plan
- After reset, `iq_count`=2, inst1 ADD r1←r2,r3, inst2 MUL r4←r1,r5 → `select_instruction`=10; next cycle iss1 tag 1 qj=qk=0, iss2 tag 4 qj=1 qk=0.
- Issue three ADDs then a fourth ADD at head, no CDB → `select_instruction`=00, `iss1_valid`=0; `cdb_tag`=2 → fourth ADD issues next cycle with tag 2.
- Pair ADD r1, SUB r1 (same dest), then ADD r6←r1 → r6's qj = slot2's tag (2).
- MUL r3 pending (tag 4); cycle with `cdb_valid`, `cdb_tag`=4 and ADD r7←r3 at head → issued qj=0; `rstat_tag[3]` cleared.
- Pair ADD, MUL with mul RS full → `select_instruction`=01 only ADD issued; pair MUL, ADD with mul full → 00.
- Assert `rst_n` low mid-issue with busy entries → all outputs 0 immediately; after release eligible ADD gets tag 1.
